// File: rtl/foxtrot_rename_pkg.sv
`default_nettype none
// ============================================================================
// Module   : foxtrot_rename_pkg
// Purpose  : Shared types and constants for the rename-recovery walk: walk
//            FSM states, architectural-register sentinels and the layout of
//            one ROB rename field.
// Revision : 1.0  initial release
// ============================================================================
package foxtrot_rename_pkg;

    // Walk controller states
    typedef enum logic [1:0] {
        WS_IDLE  = 2'd0,
        WS_WALK  = 2'd1,
        WS_DRAIN = 2'd2,
        WS_DONE  = 2'd3
    } walk_state_e;

    // ARN codes that never own a map-table entry
    localparam int unsigned ARN_INVALID = 62;
    localparam int unsigned ARN_ZERO    = 63;

    // Default geometry of a ROB rename field
    localparam int unsigned C_ROB_ARN_BITS = 6;
    localparam int unsigned C_ROB_PRN_BITS = 6;
    localparam int unsigned C_ROB_MAX_OPS  = 3;

    // Rename information stored per ROB entry
    typedef struct packed {
        logic [C_ROB_MAX_OPS-1:0]                     op_valid;
        logic [C_ROB_MAX_OPS-1:0][C_ROB_ARN_BITS-1:0] arn;
        logic [C_ROB_MAX_OPS-1:0][C_ROB_PRN_BITS-1:0] old_prn;
        logic [C_ROB_MAX_OPS-1:0][C_ROB_PRN_BITS-1:0] new_prn;
    } rob_rename_t;

    // True when an ARN names a real, mappable register
    function automatic logic arn_is_real(input logic [31:0] arn);
        return (arn != ARN_INVALID) && (arn != ARN_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rename_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rename_walk_ctrl
// Purpose  : On a squash, walks the ROB from the youngest entry backwards,
//            restoring the rename map with the overwritten mappings and
//            returning the speculatively allocated PRNs to the free list.
//            Optional: define RENAME_WALK_STATS_EN to add a saturating
//            walk_cycles counter of stalled cycles.
// Revision : 1.0  initial release
// ============================================================================
module rename_walk_ctrl
    import foxtrot_rename_pkg::*;
#(
    parameter int ARN_BITS     = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int ROB_BITS     = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_valid,
    input  logic [ROB_BITS-1:0]                    flush_head,
    input  logic [ROB_BITS:0]                      flush_count,
    output logic                                   walk_rd_en,
    output logic [ROB_BITS-1:0]                    walk_rd_idx,
    input  logic [MAX_OPERANDS-1:0]                walk_rd_op_valid,
    input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  walk_rd_arn,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  walk_rd_old_prn,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  walk_rd_new_prn,
    output logic [MAX_OPERANDS-1:0]                restore_valid,
    output logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  restore_arn,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  restore_prn,
    output logic [MAX_OPERANDS-1:0]                free_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns,
    output logic                                   rename_stall,
    output logic                                   walk_done
`ifdef RENAME_WALK_STATS_EN
    ,
    output logic [15:0]                            walk_cycles
`endif
);

    walk_state_e               r_state;
    walk_state_e               w_state_nxt;
    logic [ROB_BITS-1:0]       r_idx;
    logic [ROB_BITS-1:0]       w_idx_nxt;
    logic [ROB_BITS:0]         r_count;
    logic [ROB_BITS:0]         w_count_nxt;
    logic                      r_rd_pend;
    logic [MAX_OPERANDS-1:0]   w_live;

    // State, walk pointer, remaining count and read-pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WS_IDLE;
            r_idx     <= '0;
            r_count   <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_count   <= w_count_nxt;
            r_rd_pend <= (r_state == WS_WALK);
        end
    end

    // Next-state logic: one ROB read per WALK cycle, moving toward older entries
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        case (r_state)
            WS_IDLE: begin
                if (flush_valid) begin
                    if (flush_count == '0) begin
                        w_state_nxt = WS_DONE;
                    end else begin
                        w_state_nxt = WS_WALK;
                        w_idx_nxt   = flush_head;
                        w_count_nxt = flush_count;
                    end
                end
            end
            WS_WALK: begin
                // Natural modulo wrap takes index 0 to the top of the ROB
                w_idx_nxt   = r_idx - ROB_BITS'(1);
                w_count_nxt = r_count - (ROB_BITS+1)'(1);
                if (r_count == (ROB_BITS+1)'(1)) begin
                    w_state_nxt = WS_DRAIN;
                end
            end
            // DRAIN covers the return cycle of the final read
            WS_DRAIN: w_state_nxt = WS_DONE;
            WS_DONE:  w_state_nxt = WS_IDLE;
            default:  w_state_nxt = WS_IDLE;
        endcase
    end

    // Read strobe and status outputs decoded from the state
    always_comb begin
        walk_rd_en   = (r_state == WS_WALK);
        // Index is masked outside WALK so idle outputs stay at zero
        walk_rd_idx  = (r_state == WS_WALK) ? r_idx : '0;
        rename_stall = (r_state != WS_IDLE);
        walk_done    = (r_state == WS_DONE);
    end

    // Return-cycle decode: restore old mappings and free new PRNs for live slots
    always_comb begin
        w_live        = '0;
        restore_valid = '0;
        restore_arn   = '0;
        restore_prn   = '0;
        free_valid    = '0;
        free_prns     = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            w_live[i] = r_rd_pend && walk_rd_op_valid[i] &&
                        arn_is_real(32'(walk_rd_arn[i]));
        end
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (w_live[i]) begin
                free_valid[i]    = 1'b1;
                free_prns[i]     = walk_rd_new_prn[i];
                restore_valid[i] = 1'b1;
                // A lower slot already writing this ARN carries the oldest mapping
                for (int j = 0; j < i; j++) begin
                    if (w_live[j] && (walk_rd_arn[j] == walk_rd_arn[i])) begin
                        restore_valid[i] = 1'b0;
                    end
                end
                if (restore_valid[i]) begin
                    restore_arn[i] = walk_rd_arn[i];
                    restore_prn[i] = walk_rd_old_prn[i];
                end
            end
        end
    end

`ifdef RENAME_WALK_STATS_EN
    logic [15:0] r_walk_cycles;

    // Saturating count of cycles spent with renaming blocked
    always_ff @(posedge clk) begin
        if (rst) begin
            r_walk_cycles <= '0;
        end else if (rename_stall && (r_walk_cycles != 16'hFFFF)) begin
            r_walk_cycles <= r_walk_cycles + 16'd1;
        end
    end

    assign walk_cycles = r_walk_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_walk_ctrl
// Purpose  : Self-checking bench for rename_walk_ctrl against a ROB memory
//            model and a timeline reference derived from flush head/count.
// Revision : 1.0  initial release
// ============================================================================
module tb_rename_walk_ctrl;

    localparam int AB    = 6;
    localparam int PB    = 6;
    localparam int MO    = 3;
    localparam int RB    = 5;
    localparam int DEPTH = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush_valid;
    logic [RB-1:0]          flush_head;
    logic [RB:0]            flush_count;
    logic                   walk_rd_en;
    logic [RB-1:0]          walk_rd_idx;
    logic [MO-1:0]          walk_rd_op_valid;
    logic [MO-1:0][AB-1:0]  walk_rd_arn;
    logic [MO-1:0][PB-1:0]  walk_rd_old_prn;
    logic [MO-1:0][PB-1:0]  walk_rd_new_prn;
    logic [MO-1:0]          restore_valid;
    logic [MO-1:0][AB-1:0]  restore_arn;
    logic [MO-1:0][PB-1:0]  restore_prn;
    logic [MO-1:0]          free_valid;
    logic [MO-1:0][PB-1:0]  free_prns;
    logic                   rename_stall;
    logic                   walk_done;
`ifdef RENAME_WALK_STATS_EN
    logic [15:0]            walk_cycles;
    int                     stall_model = 0;
`endif

    always #5 clk = ~clk;

    rename_walk_ctrl #(
        .ARN_BITS(AB), .PRN_BITS(PB), .MAX_OPERANDS(MO), .ROB_BITS(RB)
    ) dut (
        .clk(clk), .rst(rst),
        .flush_valid(flush_valid), .flush_head(flush_head), .flush_count(flush_count),
        .walk_rd_en(walk_rd_en), .walk_rd_idx(walk_rd_idx),
        .walk_rd_op_valid(walk_rd_op_valid), .walk_rd_arn(walk_rd_arn),
        .walk_rd_old_prn(walk_rd_old_prn), .walk_rd_new_prn(walk_rd_new_prn),
        .restore_valid(restore_valid), .restore_arn(restore_arn), .restore_prn(restore_prn),
        .free_valid(free_valid), .free_prns(free_prns),
        .rename_stall(rename_stall), .walk_done(walk_done)
`ifdef RENAME_WALK_STATS_EN
        , .walk_cycles(walk_cycles)
`endif
    );

    int errors = 0;
    int checks = 0;

    // ROB rename-field memory
    logic [MO-1:0]          rob_v   [DEPTH];
    logic [MO-1:0][AB-1:0]  rob_arn [DEPTH];
    logic [MO-1:0][PB-1:0]  rob_old [DEPTH];
    logic [MO-1:0][PB-1:0]  rob_new [DEPTH];

    // Observations from the most recent walk
    logic [MO-1:0]          cap_rv, cap_fv;
    logic [MO-1:0][AB-1:0]  cap_ra;
    logic [MO-1:0][PB-1:0]  cap_rp, cap_fp;
    int                     n_restore, n_free;
    int                     read_log[$];

    // Expected map-table and free-list effects of undoing one ROB entry
    function automatic void model_entry(input int e,
                                        output logic [MO-1:0] rv, output logic [MO-1:0] fv,
                                        output logic [MO-1:0][AB-1:0] ra,
                                        output logic [MO-1:0][PB-1:0] rp,
                                        output logic [MO-1:0][PB-1:0] fp);
        logic [MO-1:0] live;
        rv = '0; fv = '0; ra = '0; rp = '0; fp = '0;
        for (int i = 0; i < MO; i++)
            live[i] = rob_v[e][i] && (int'(rob_arn[e][i]) < 62);
        for (int i = 0; i < MO; i++) begin
            if (live[i]) begin
                bit seen_before = 1'b0;
                fv[i] = 1'b1;
                fp[i] = rob_new[e][i];
                for (int j = 0; j < i; j++)
                    if (live[j] && rob_arn[e][j] == rob_arn[e][i]) seen_before = 1'b1;
                if (!seen_before) begin
                    rv[i] = 1'b1;
                    ra[i] = rob_arn[e][i];
                    rp[i] = rob_old[e][i];
                end
            end
        end
    endfunction

    task automatic fill_rob_random();
        for (int e = 0; e < DEPTH; e++) begin
            for (int i = 0; i < MO; i++) begin
                int r;
                rob_v[e][i]   = ($urandom_range(0, 3) != 0);
                r             = $urandom_range(0, 9);
                rob_arn[e][i] = (r < 8) ? AB'(r) : AB'(54 + r);
                rob_old[e][i] = PB'($urandom);
                rob_new[e][i] = PB'($urandom);
            end
        end
    endtask

    // ROB read port: data for the index strobed last cycle, garbage otherwise
    task automatic drive_rob(input logic prev_en, input int prev_idx);
        if (prev_en) begin
            walk_rd_op_valid = rob_v[prev_idx];
            walk_rd_arn      = rob_arn[prev_idx];
            walk_rd_old_prn  = rob_old[prev_idx];
            walk_rd_new_prn  = rob_new[prev_idx];
        end else begin
            walk_rd_op_valid = '1;
            for (int i = 0; i < MO; i++) begin
                walk_rd_arn[i]     = AB'($urandom_range(0, 7));
                walk_rd_old_prn[i] = PB'($urandom);
                walk_rd_new_prn[i] = PB'($urandom);
            end
        end
    endtask

    // One flush of n entries from head h; optional second flush at extra_t and reset at rst_t
    task automatic do_walk(input int h, input int n, input int extra_t, input int rst_t);
        int            last;
        logic          prev_en;
        int            prev_idx;
        logic          e_rd, e_stall, e_done, e_ret;
        logic [RB-1:0] e_idx;
        logic [MO-1:0]         e_rv, e_fv;
        logic [MO-1:0][AB-1:0] e_ra;
        logic [MO-1:0][PB-1:0] e_rp, e_fp;
        last = (n == 0) ? 1 : n + 2;
        n_restore = 0; n_free = 0; read_log.delete();
        cap_rv = '0; cap_fv = '0; cap_ra = '0; cap_rp = '0; cap_fp = '0;
        prev_en = 1'b0; prev_idx = 0;
        for (int t = 0; t <= last + 1; t++) begin
            flush_valid = (t == 0) || (t == extra_t);
            flush_head  = (t == 0) ? RB'(h) : RB'(h ^ 10);
            flush_count = (t == 0) ? (RB+1)'(n) : (RB+1)'(7);
            rst         = (t == rst_t);
            drive_rob(prev_en, prev_idx);
            #1;
            e_rv = '0; e_fv = '0; e_ra = '0; e_rp = '0; e_fp = '0;
            if (rst_t >= 0 && t > rst_t) begin
                e_rd = 1'b0; e_stall = 1'b0; e_done = 1'b0; e_ret = 1'b0;
            end else begin
                e_rd    = (t >= 1) && (t <= n);
                e_ret   = (t >= 2) && (t <= n + 1);
                e_stall = (t >= 1) && (t <= last);
                e_done  = (t == last);
            end
            e_idx = e_rd ? RB'((h - (t - 1) + 64) % DEPTH) : '0;
            if (e_ret) model_entry((h - (t - 2) + 64) % DEPTH, e_rv, e_fv, e_ra, e_rp, e_fp);

            checks++;
            if (walk_rd_en !== e_rd) begin
                errors++; $display("FAIL rd_en t=%0d got=%b exp=%b", t, walk_rd_en, e_rd);
            end
            checks++;
            if (walk_rd_idx !== e_idx) begin
                errors++; $display("FAIL rd_idx t=%0d got=%0d exp=%0d", t, walk_rd_idx, e_idx);
            end
            checks++;
            if (rename_stall !== e_stall) begin
                errors++; $display("FAIL stall t=%0d got=%b exp=%b", t, rename_stall, e_stall);
            end
            checks++;
            if (walk_done !== e_done) begin
                errors++; $display("FAIL done t=%0d got=%b exp=%b", t, walk_done, e_done);
            end
            checks++;
            if (restore_valid !== e_rv || free_valid !== e_fv) begin
                errors++; $display("FAIL valids t=%0d got rv=%b fv=%b exp rv=%b fv=%b",
                                   t, restore_valid, free_valid, e_rv, e_fv);
            end
            checks++;
            if (restore_arn !== e_ra || restore_prn !== e_rp) begin
                errors++; $display("FAIL restore_data t=%0d got arn=%h prn=%h exp arn=%h prn=%h",
                                   t, restore_arn, restore_prn, e_ra, e_rp);
            end
            checks++;
            if (free_prns !== e_fp) begin
                errors++; $display("FAIL free_prns t=%0d got=%h exp=%h", t, free_prns, e_fp);
            end
`ifdef RENAME_WALK_STATS_EN
            checks++;
            if (int'(walk_cycles) !== stall_model) begin
                errors++; $display("FAIL walk_cycles t=%0d got=%0d exp=%0d", t, walk_cycles, stall_model);
            end
            if (rst) stall_model = 0;
            else if (e_stall) stall_model++;
`endif
            if (e_ret) begin
                cap_rv = restore_valid; cap_fv = free_valid; cap_ra = restore_arn;
                cap_rp = restore_prn;   cap_fp = free_prns;
            end
            n_restore += $countones(restore_valid);
            n_free    += $countones(free_valid);
            if (walk_rd_en) read_log.push_back(int'(walk_rd_idx));
            prev_en  = walk_rd_en;
            prev_idx = int'(walk_rd_idx);
            @(posedge clk); #1;
        end
        flush_valid = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_valid = 1'b1; flush_head = 5'd3; flush_count = 6'd4;
        for (int k = 0; k < 3; k++) begin
            drive_rob(1'b0, 0);
            #1;
            checks++;
            if ({walk_rd_en, walk_rd_idx, rename_stall, walk_done, restore_valid, free_valid} !== '0) begin
                errors++; $display("FAIL reset_outputs cyc=%0d got en=%b idx=%0d st=%b dn=%b rv=%b fv=%b exp all 0",
                                   k, walk_rd_en, walk_rd_idx, rename_stall, walk_done, restore_valid, free_valid);
            end
            @(posedge clk); #1;
        end
`ifdef RENAME_WALK_STATS_EN
        stall_model = 0;
`endif
        rst = 1'b0; flush_valid = 1'b0;
        #1;
        checks++;
        if ({walk_rd_en, rename_stall, walk_done, restore_valid, free_valid} !== '0) begin
            errors++; $display("FAIL post_reset_idle got en=%b st=%b dn=%b exp 0", walk_rd_en, rename_stall, walk_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int e = 2; e <= 4; e++) begin
            rob_v[e] = '1;
            for (int i = 0; i < MO; i++) begin
                rob_arn[e][i] = AB'(e * 3 + i);
                rob_old[e][i] = PB'(e * 3 + i + 20);
                rob_new[e][i] = PB'(e * 3 + i + 40);
            end
        end
        do_walk(4, 3, -1, -1);
        checks++;
        if (n_restore != 9 || n_free != 9) begin
            errors++; $display("FAIL basic_counts got restores=%0d frees=%0d exp 9/9", n_restore, n_free);
        end
        checks++;
        if (read_log.size() != 3 || read_log[0] != 4 || read_log[1] != 3 || read_log[2] != 2) begin
            errors++; $display("FAIL basic_reads got=%p exp '{4,3,2}", read_log);
        end
    endtask

    task automatic test_wrap();
        do_walk(1, 3, -1, -1);
        checks++;
        if (read_log.size() != 3 || read_log[0] != 1 || read_log[1] != 0 || read_log[2] != 31) begin
            errors++; $display("FAIL wrap_reads got=%p exp '{1,0,31}", read_log);
        end
    endtask

    task automatic test_zero();
        do_walk(5, 0, -1, -1);
        checks++;
        if (read_log.size() != 0 || n_restore != 0 || n_free != 0) begin
            errors++; $display("FAIL zero_count got reads=%0d restores=%0d frees=%0d exp 0",
                               read_log.size(), n_restore, n_free);
        end
    endtask

    task automatic test_dup_arn();
        rob_v[9]   = 3'b111;
        rob_arn[9] = {6'd63, 6'd7, 6'd7};
        rob_old[9] = {6'd55, 6'd11, 6'd10};
        rob_new[9] = {6'd56, 6'd41, 6'd40};
        do_walk(9, 1, -1, -1);
        checks++;
        if (cap_rv !== 3'b001 || cap_ra[0] !== 6'd7 || cap_rp[0] !== 6'd10) begin
            errors++; $display("FAIL dup_restore got rv=%b arn0=%0d prn0=%0d exp 001/7/10", cap_rv, cap_ra[0], cap_rp[0]);
        end
        checks++;
        if (cap_fv !== 3'b011 || cap_fp[0] !== 6'd40 || cap_fp[1] !== 6'd41) begin
            errors++; $display("FAIL dup_free got fv=%b p0=%0d p1=%0d exp 011/40/41", cap_fv, cap_fp[0], cap_fp[1]);
        end
    endtask

    task automatic test_reset_mid_walk();
        fill_rob_random();
        do_walk(20, 5, -1, 3);
        checks++;
        if (read_log.size() != 3) begin
            errors++; $display("FAIL mid_reset_reads got=%0d exp=3", read_log.size());
        end
    endtask

    task automatic test_second_flush();
        fill_rob_random();
        do_walk(12, 4, 2, -1);
        checks++;
        if (read_log.size() != 4) begin
            errors++; $display("FAIL second_flush_reads got=%0d exp=4", read_log.size());
        end
    endtask

    task automatic test_full_rob();
        bit seen [DEPTH];
        int uniq = 0;
        fill_rob_random();
        do_walk(7, DEPTH, -1, -1);
        foreach (read_log[k]) if (!seen[read_log[k]]) begin seen[read_log[k]] = 1'b1; uniq++; end
        checks++;
        if (read_log.size() != DEPTH || uniq != DEPTH) begin
            errors++; $display("FAIL full_rob got reads=%0d unique=%0d exp 32/32", read_log.size(), uniq);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            fill_rob_random();
            do_walk($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), -1, -1);
        end
    endtask

    initial begin
        rst = 1'b1; flush_valid = 1'b0; flush_head = '0; flush_count = '0;
        drive_rob(1'b0, 0);
        for (int e = 0; e < DEPTH; e++) begin
            rob_v[e] = '0; rob_arn[e] = '0; rob_old[e] = '0; rob_new[e] = '0;
        end
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_dup_arn();
        test_reset_mid_walk();
        test_second_flush();
        test_full_rob();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
